// File: rtl/byte_decode_stream.sv
// byte_decode_stream: streaming ByteDecode_d for the ML-KEM datapath.
// Unpacks little-endian d-bit fields from a byte stream, one coefficient
// per handshake, for 1..4 polynomials of 256 coefficients each.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, d_i, npoly_i   job start with field width and poly count
//   busy_o, done_o, err_o   job status (done/err are one-cycle pulses)
//   in_data_i/in_valid_i/in_ready_o        byte input handshake
//   coef_o/coef_valid_o/coef_ready_i       coefficient output handshake
//   coef_idx_o, poly_idx_o  position of coef_o within the job
module byte_decode_stream #(
    parameter int DMAX = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  d_i,
    input  logic [2:0]  npoly_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [11:0] coef_o,
    output logic        coef_valid_o,
    input  logic        coef_ready_i,
    output logic [7:0]  coef_idx_o,
    output logic [1:0]  poly_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  d_q, d_d;
    logic [2:0]  np_q, np_d;
    logic [19:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  cidx_q, cidx_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        err_q, err_d;

    logic        run;
    logic [4:0]  d_ext;
    logic [11:0] mask12;
    logic [11:0] raw;
    logic        legal;
    logic        in_hs;
    logic        coef_hs;
    logic        last_poly;

    assign run   = (state_q == S_RUN);
    assign d_ext = {1'b0, d_q};

    // d never exceeds 12 while running, so the low 12 bits hold the field.
    assign mask12 = 12'hFFF >> (4'd12 - d_q);
    assign raw    = acc_q[11:0] & mask12;

    // Only d == 12 can exceed q; raw < 4096 < 2q needs one subtraction.
    always_comb begin
        coef_o = raw;
        if (d_q == 4'd12 && raw >= 12'd3329) begin
            coef_o = raw - 12'd3329;
        end
    end

    assign in_ready_o   = run && (cnt_q < d_ext);
    assign coef_valid_o = run && (cnt_q >= d_ext);
    assign in_hs        = in_ready_o && in_valid_i;
    assign coef_hs      = coef_valid_o && coef_ready_i;

    assign legal = (d_i != 4'd0) && (int'(d_i) <= DMAX)
                && (npoly_i != 3'd0) && (npoly_i <= 3'd4);

    assign last_poly = ({1'b0, pidx_q} == (np_q - 3'd1));

    assign busy_o     = run;
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign coef_idx_o = cidx_q;
    assign poly_idx_o = pidx_q;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        np_d    = np_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cidx_d  = cidx_q;
        pidx_d  = pidx_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (legal) begin
                        d_d     = d_i;
                        np_d    = npoly_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        cidx_d  = '0;
                        pidx_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (in_hs) begin
                    acc_d = acc_q | (20'(in_data_i) << cnt_q);
                    cnt_d = cnt_q + 5'd8;
                end else if (coef_hs) begin
                    acc_d  = acc_q >> d_q;
                    cnt_d  = cnt_q - d_ext;
                    cidx_d = cidx_q + 8'd1;
                    if (cidx_q == 8'd255) begin
                        if (last_poly) begin
                            pidx_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            pidx_d = pidx_q + 2'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                cidx_d  = '0;
                pidx_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            np_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            cidx_q  <= '0;
            pidx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            np_q    <= np_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cidx_q  <= cidx_d;
            pidx_q  <= pidx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_byte_decode_stream.sv
// tb_byte_decode_stream: directed and model-checked bench for
// byte_decode_stream (throughput, stalls, errors, reset abort).
module tb_byte_decode_stream;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  d_i;
    logic [2:0]  npoly_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] coef_o;
    logic        coef_valid_o;
    logic        coef_ready_i;
    logic [7:0]  coef_idx_o;
    logic [1:0]  poly_idx_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] byte_q[$];
    int         exp_q[$];
    int         hs_cyc[$];
    int         first_cyc;

    byte_decode_stream #(.DMAX(12)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .d_i          (d_i),
        .npoly_i      (npoly_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .coef_o       (coef_o),
        .coef_valid_o (coef_valid_o),
        .coef_ready_i (coef_ready_i),
        .coef_idx_o   (coef_idx_o),
        .poly_idx_o   (poly_idx_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Golden ByteDecode_d: bit i of the stream is bit (i%8) of byte i/8.
    task automatic build_exp(input int d, input int np);
        int v;
        int bp;
        logic [7:0] b;
        exp_q.delete();
        for (int k = 0; k < 256 * np; k++) begin
            v = 0;
            for (int j = 0; j < d; j++) begin
                bp = k * d + j;
                b = byte_q[bp / 8];
                if (b[bp % 8]) v = v | (1 << j);
            end
            if (d == 12) v = v % 3329;
            exp_q.push_back(v);
        end
    endtask

    task automatic rand_bytes(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic run_job(input int d, input int np, input bit stall,
                           input bit mid_start);
        int bi = 0;
        int k = 0;
        int guard = 0;
        int total = 256 * np;
        bit r;
        hs_cyc.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        d_i     = 4'(d);
        npoly_i = 3'(np);
        @(negedge clk_i);
        start_i = 1'b0;
        check("rdy_after_start", in_ready_o, 1);
        check("busy_run", busy_o, 1);
        while (k < total && guard < 20000) begin
            check("excl", in_ready_o & coef_valid_o, 0);
            in_valid_i   = 1'b0;
            coef_ready_i = 1'b0;
            in_data_i    = 8'($urandom);
            start_i      = 1'b0;
            if (mid_start && k == 10) begin
                start_i = 1'b1;
                d_i     = 4'd4;
                npoly_i = 3'd1;
            end
            if (coef_valid_o) begin
                check("coef", coef_o, exp_q[k]);
                check("cidx", coef_idx_o, k % 256);
                check("pidx", poly_idx_o, k / 256);
                r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                coef_ready_i = r;
                if (r) begin
                    hs_cyc.push_back(cyc);
                    k++;
                end
            end else if (in_ready_o && bi < byte_q.size()) begin
                r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_valid_i = r;
                in_data_i  = byte_q[bi];
                if (r) begin
                    if (bi == 0) first_cyc = cyc;
                    bi++;
                end
            end
            @(negedge clk_i);
            guard++;
        end
        in_valid_i   = 1'b0;
        coef_ready_i = 1'b0;
        start_i      = 1'b0;
        check("coef_count", k, total);
        check("done_pulse", done_o, 1);
        check("busy_done", busy_o, 0);
        check("cidx_done", coef_idx_o, 0);
        check("pidx_done", poly_idx_o, 0);
        @(negedge clk_i);
        check("done_once", done_o, 0);
        check("idle_rdy", in_ready_o, 0);
    endtask

    task automatic bad_start(input int d, input int np);
        @(negedge clk_i);
        start_i = 1'b1;
        d_i     = 4'(d);
        npoly_i = 3'(np);
        @(negedge clk_i);
        start_i = 1'b0;
        check("err_pulse", err_o, 1);
        check("err_busy", busy_o, 0);
        @(negedge clk_i);
        check("err_once", err_o, 0);
        check("err_idle", busy_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_rdy"}, in_ready_o, 0);
        check({tag, "_cv"}, coef_valid_o, 0);
        check({tag, "_coef"}, coef_o, 0);
        check({tag, "_cidx"}, coef_idx_o, 0);
        check({tag, "_pidx"}, poly_idx_o, 0);
    endtask

    initial begin
        int got;
        int guard;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        d_i          = 4'd0;
        npoly_i      = 3'd0;
        in_data_i    = 8'h00;
        in_valid_i   = 1'b1;
        coef_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_no_accept", in_ready_o, 0);
        in_valid_i = 1'b0;

        // d=12: 4095 mod 3329 = 766, then zeros; 3 bytes -> 2 coefs.
        byte_q.delete();
        byte_q.push_back(8'hFF);
        byte_q.push_back(8'h0F);
        for (int i = 2; i < 384; i++) byte_q.push_back(8'h00);
        exp_q.delete();
        exp_q.push_back(766);
        for (int i = 1; i < 256; i++) exp_q.push_back(0);
        run_job(12, 1, 1'b0, 1'b0);
        check("d12_thru", hs_cyc[1] - first_cyc, 4);

        // d=1: 0xA5 -> 1,0,1,0,0,1,0,1 on consecutive cycles.
        byte_q.delete();
        byte_q.push_back(8'hA5);
        for (int i = 1; i < 32; i++) byte_q.push_back(8'h00);
        exp_q = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 8; i < 256; i++) exp_q.push_back(0);
        run_job(1, 1, 1'b0, 1'b0);
        check("d1_b2b", hs_cyc[7] - hs_cyc[0], 7);

        // d=4, two polys of 0x21 -> alternating 1,2.
        byte_q.delete();
        for (int i = 0; i < 256; i++) byte_q.push_back(8'h21);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back((i % 2 == 0) ? 1 : 2);
        run_job(4, 2, 1'b0, 1'b0);

        // d=10 random data with stalls on both sides.
        rand_bytes(320);
        build_exp(10, 1);
        run_job(10, 1, 1'b1, 1'b0);

        // d=12 random, three polys, stalls: exercises the mod-q path.
        rand_bytes(384 * 3);
        build_exp(12, 3);
        run_job(12, 3, 1'b1, 1'b0);

        bad_start(0, 1);
        bad_start(13, 1);
        bad_start(5, 0);
        bad_start(5, 5);

        // d=8 job with a d=4 start injected mid-run; must be ignored.
        rand_bytes(256);
        build_exp(8, 1);
        run_job(8, 1, 1'b0, 1'b1);

        // d=11 job aborted by reset after 5 bytes.
        @(negedge clk_i);
        start_i = 1'b1;
        d_i     = 4'd11;
        npoly_i = 3'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        got     = 0;
        guard   = 0;
        while (got < 5 && guard < 50) begin
            in_valid_i   = 1'b1;
            coef_ready_i = 1'b1;
            in_data_i    = 8'($urandom);
            if (in_ready_o) got++;
            @(negedge clk_i);
            guard++;
        end
        in_valid_i   = 1'b0;
        coef_ready_i = 1'b0;
        check("abort_bytes", got, 5);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_all_zero("abort");
        @(negedge clk_i);
        check("abort_no_done", done_o, 0);
        check("abort_no_err", err_o, 0);

        rand_bytes(352);
        build_exp(11, 1);
        run_job(11, 1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_decode_stream.md
# byte_decode_stream

Streaming, runtime-configurable implementation of ByteDecode_d for the ML-KEM datapath. It accepts an 8-bit byte stream, unpacks little-endian d-bit fields through a bit accumulator, reduces each field mod m, and emits one coefficient per handshake, sequencing 1..4 consecutive polynomials per job. It sits between the byte-oriented ciphertext/key input buffer and the coefficient memory write port.

## Interface
- `DMAX`, default 12: largest supported d; fixes the coefficient width at 12 bits. Not overridable below 12.
- `clk_i`  in  1  single clock; all logic on the rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  job start; sampled only in IDLE
- `d_i`  in  4  field width d; latched on start; legal 1..12
- `npoly_i`  in  3  polynomials per job; latched on start; legal 1..4
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  one-cycle pulse at job completion
- `err_o`  out  1  one-cycle pulse when start sees illegal d_i or npoly_i
- `in_data_i`  in  8  input byte
- `in_valid_i`  in  1  byte valid
- `in_ready_o`  out  1  byte accepted when valid && ready
- `coef_o`  out  12  decoded coefficient, zero-extended
- `coef_valid_o`  out  1  coefficient valid
- `coef_ready_i`  in  1  coefficient accepted when valid && ready
- `coef_idx_o`  out  8  index 0..255 of coef_o within its polynomial
- `poly_idx_o`  out  2  polynomial index of coef_o

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_i with legal d_i and npoly_i -> latch both, clear accumulator, bit count, coef_idx and poly_idx -> RUN. Illegal values -> err_o pulse next cycle, stay IDLE. start_i outside IDLE is ignored.
- Accumulator: 20 bits (acc), bit count cnt 0..19.
  - `in_ready_o = (state==RUN) && (cnt < d)`.
  - On byte accept: `acc[cnt +: 8] |= in_data_i`, `cnt += 8`.
  - `coef_valid_o = (state==RUN) && (cnt >= d)`. in_ready_o and coef_valid_o are never high together.
- Coefficient:
  - `raw = acc[d-1:0]`.
  - d==12: `coef_o = raw>=3329 ? raw-3329 : raw`; raw < 4096, so one subtraction is sufficient.
  - d<12: `coef_o = raw`.
- On coefficient handshake: `acc >>= d`, `cnt -= d`, coef_idx increments.
  - coef_idx wrap 255->0: poly_idx increments. cnt is exactly 0 here, because each polynomial is 32·d bytes.
  - Handshake with coef_idx==255 and poly_idx==npoly-1 -> DONE.
- DONE: done_o=1 for one cycle -> IDLE. coef_idx_o/poly_idx_o return to 0.
- Outputs coef_o, coef_idx_o and poly_idx_o are derived from registered state only; no input-to-output combinational paths except through registers.

## Timing
- Reset: state IDLE; acc=0, cnt=0. busy_o, done_o, err_o, in_ready_o, coef_valid_o, coef_o, coef_idx_o and poly_idx_o all 0.
- Byte accepted in cycle t that makes cnt>=d -> coef_valid_o high in t+1.
- First in_ready_o occurs the cycle after the accepted start_i.
- coef_valid_o held with coef_o, coef_idx_o and poly_idx_o stable until coef_ready_i; no input accepted meanwhile.
- Back-to-back coefficients without stall when cnt>=2d (e.g. d≤4 after one byte).
- Throughput, d=12: 3 bytes -> 2 coefficients in 5 cycles.
- Last handshake in cycle t -> done_o in t+1, busy_o low from t+1, new start accepted from t+2.
- rst_i mid-job aborts immediately. Partial bits are discarded, and no done_o or err_o is produced.
- Bytes presented while IDLE/DONE are not accepted (in_ready_o=0).

## Test plan
- d=12, npoly=1, first bytes 0xFF,0x0F,0x00 -> coef 766 (4095 mod 3329) idx0, coef 0 idx1. Remaining 381 bytes 0x00 give 254 zeros, then done_o pulse one cycle after idx255 handshake.
- d=1, byte 0xA5 -> coefs 1,0,1,0,0,1,0,1 at idx 0..7, issued on consecutive cycles with coef_ready_i=1.
- d=4, npoly=2, 256 bytes of 0x21 -> 512 coefs alternating 1,2. poly_idx_o 0 for the first 256 and 1 for the next 256; done_o single pulse.
- d=10, random bytes with random coef_ready_i and in_valid_i stalls -> output matches the golden ByteDecode_10 model. coef_o stays stable while stalled, and in_ready_o && coef_valid_o never both high.
- Illegal start, d_i=0 then d_i=13 then npoly_i=0 -> err_o pulse each time, busy_o stays 0. A start_i during RUN is ignored (latched d unchanged).
- rst_i asserted after 5 bytes of a d=11 job -> all outputs 0 the next cycle. A fresh d=11 job then decodes correctly from its first byte.
